serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial addition sequencer built around the team's `half_adder` cell. It captures two WIDTH-bit operands on a start request and feeds them LSB-first, one bit per clock, through a single full-adder slice formed from two `half_adder` instances plus an OR. A registered carry links the bits. The block presents the final sum and carry-out with a one-cycle done pulse. It is the controller that time-shares one adder slice across all bit positions, trading latency for area.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, asynchronous and active-high
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the edge that accepts start
- b  input  WIDTH  operand B; sampled on the edge that accepts start
- busy  output  1  high while bits are being processed (RUN state)
- done  output  1  one-cycle pulse; sum and carry_out are valid and new
- sum  output  WIDTH  result of a+b modulo 2^WIDTH
- carry_out  output  1  bit WIDTH of a+b

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing one bit per cycle.
  - DONE: single cycle; asserts done.
- Transitions:
  - IDLE → RUN when start=1.
  - RUN → DONE when bit counter = WIDTH-1.
  - DONE → IDLE unconditionally.
- On acceptance of start:
  - Operand shift registers ← a, b.
  - Carry register ← 0.
  - Bit counter ← 0.
  - Internal result shift register ← 0.
- Each RUN cycle:
  - Slice inputs are operand-register bit 0 of A and B, plus the carry register.
  - HA1 computes (a0, b0) → (s1, c1).
  - HA2 computes (s1, cin) → (s, c2).
  - cout = c1 | c2.
  - Result register shifts right with s entering at MSB.
  - Operand registers shift right with 0 filled.
  - Carry register ← cout.
  - Counter increments.
- On the RUN→DONE edge, sum ← final result register value (including the last bit) and carry_out ← final cout.
- sum and carry_out are written only on the RUN→DONE edge. They hold their previous values during RUN and afterwards until the next completion.
- start is ignored in RUN and DONE. It is not queued; a held start is accepted on the first IDLE cycle.
- Operand changes on a/b after acceptance have no effect.
- Arithmetic is unsigned; overflow appears only on carry_out.

## Timing
- Reset values (rst=1, asynchronous):
  - State = IDLE.
  - busy=0, done=0, sum=0, carry_out=0.
  - All internal registers 0.
- Reset mid-operation aborts the addition immediately. No done pulse is produced, and outputs are cleared to 0.
- First start after reset release is honoured on the first rising edge with rst=0.
- Latency: start accepted at edge E0.
  - busy=1 after E0 through E(WIDTH-1).
  - sum, carry_out and done=1 are visible after edge EWIDTH.
  - done=0 and state IDLE after E(WIDTH+1).
- Throughput: one addition per WIDTH+2 cycles when start is held high. Acceptance occurs at E0, E(WIDTH+2), and so on.
- busy and done are never high in the same cycle.
- done is high for exactly one cycle per accepted start.

## Test plan
- Reset, then WIDTH=8, a=0x00, b=0x00, start pulse → done after 8 edges; sum=0x00, carry_out=0; busy high exactly 8 cycles.
- a=0xFF, b=0x01 → sum=0x00, carry_out=1 (full carry ripple through all bits). Then a=0xA5, b=0x5A → sum=0xFF, carry_out=0. Then a=0xFF, b=0xFF → sum=0xFE, carry_out=1.
- During RUN of a=0x12+b=0x34, pulse start with a=0xFF, b=0xFF at cycle 3 → result sum=0x46, carry_out=0; exactly one done pulse. Outputs hold the prior result (0xFE, 1) until the done edge.
- Assert rst asynchronously mid-clock at RUN cycle 4 of a=0x80+b=0x80 → busy, done, sum, carry_out go 0 immediately with no done. Release reset and run a=0x80, b=0x80 → sum=0x00, carry_out=1.
- Hold start=1 continuously with a=0x01, b=0x01 → done pulses every 10 cycles; each result is sum=0x02, carry_out=0.
- Exhaustive sweep with WIDTH=2 parameterisation: all 16 (a,b) pairs → {carry_out,sum} = a+b for every pair; latency 2 edges to done.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer time-sharing one full-adder slice
// Operands shift out LSB-first; the result shifts in at the MSB and is published on completion.

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic w_s1;
    logic w_c1;
    logic w_s;
    logic w_c2;
    logic w_cout;
    logic [WIDTH-1:0] w_res_next;

    half_adder u_ha1 (
        .i_a (r_op_a[0]),
        .i_b (r_op_b[0]),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    half_adder u_ha2 (
        .i_a (w_s1),
        .i_b (r_carry),
        .o_s (w_s),
        .o_c (w_c2)
    );

    assign w_cout     = w_c1 | w_c2;
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_res   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    // The last bit is folded straight into the published sum here.
                    if (r_cnt == LAST) begin
                        sum       <= w_res_next;
                        carry_out <= w_cout;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=2
// Stimulus pushes expected {carry_out,sum}; monitors pop and compare on every done pulse.

module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, co8;
    logic [7:0] sum8;

    logic       s2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       busy2, done2, co2;
    logic [1:0] sum2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_run8 = 0;
    int busy_run2 = 0;

    logic [8:0] q8[$];
    logic [2:0] q2[$];

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            busy_run8 = 0;
            busy_run2 = 0;
        end else begin
            if (busy8) busy_run8++;
            if (busy2) busy_run2++;
            if (done8) begin
                check("busy_done_excl8", {31'd0, busy8}, 32'd0);
                check("busy_len8", busy_run8, 8);
                busy_run8 = 0;
                if (q8.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_done8: got 0x%0h, expected no done", {co8, sum8});
                end else begin
                    check("result8", {23'd0, co8, sum8}, {23'd0, q8.pop_front()});
                end
            end
            if (done2) begin
                check("busy_len2", busy_run2, 2);
                busy_run2 = 0;
                if (q2.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_done2: got 0x%0h, expected no done", {co2, sum2});
                end else begin
                    check("result2", {29'd0, co2, sum2}, {29'd0, q2.pop_front()});
                end
            end
        end
    end

    // Called just after a rising edge with the DUT idle; inj>0 pulses an ignored start mid-run.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp,
                       input logic [8:0] prev, input int inj);
        int n;
        a8 = a; b8 = b; s8 = 1'b1;
        q8.push_back(exp);
        @(posedge clk); #1;
        s8 = 1'b0;
        a8 = 8'hC3; b8 = 8'h3C;
        check("busy_after_accept8", {31'd0, busy8}, 32'd1);
        n = 0;
        while (!done8 && n < 20) begin
            check("hold8", {23'd0, co8, sum8}, {23'd0, prev});
            if (inj != 0 && n == inj) begin
                s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                s8 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        s8 = 1'b0;
        check("latency8", n, 8);
        @(posedge clk); #1;
        check("done_drop8", {31'd0, done8}, 32'd0);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b);
        int n;
        a2 = a; b2 = b; s2 = 1'b1;
        q2.push_back({1'b0, a} + {1'b0, b});
        @(posedge clk); #1;
        s2 = 1'b0;
        n = 0;
        while (!done2 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency2", n, 2);
        @(posedge clk); #1;
    endtask

    initial begin
        int t[3];
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_out", {23'd0, co8, sum8}, 32'd0);
        rst = 1'b0;

        op8(8'h00, 8'h00, 9'h000, 9'h000, 0);
        op8(8'hFF, 8'h01, 9'h100, 9'h000, 0);
        op8(8'hA5, 8'h5A, 9'h0FF, 9'h100, 0);
        op8(8'hFF, 8'hFF, 9'h1FE, 9'h0FF, 0);
        op8(8'h12, 8'h34, 9'h046, 9'h1FE, 3);

        a8 = 8'h80; b8 = 8'h80; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_out", {23'd0, co8, sum8}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        op8(8'h80, 8'h80, 9'h100, 9'h000, 0);

        a8 = 8'h01; b8 = 8'h01; s8 = 1'b1;
        for (int k = 0; k < 3; k++) q8.push_back(9'h002);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!done8 && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            if (!done8) check("held_timeout", 32'd0, 32'd1);
            t[k] = cyc;
            if (k == 2) s8 = 1'b0;
            @(posedge clk); #1;
        end
        check("held_period_a", t[1] - t[0], 10);
        check("held_period_b", t[2] - t[1], 10);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                op2(2'(i), 2'(j));

        repeat (12) @(posedge clk);
        #1;
        check("q8_drained", q8.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
